// File: rtl/div_restoring.sv
// div_restoring: sequential restoring shift-subtract unsigned divider.
// One quotient bit is produced per clock in RUN. A zero divisor short-cuts
// straight to DONE with quotient = all ones and remainder = dividend.
// Results are registered and hold until the next accepted start.
module div_restoring #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // One restoring iteration. Shifts the next dividend bit into the partial
  // remainder and attempts to subtract the divisor. Returns {quotient bit,
  // new partial remainder}. The partial remainder is always strictly less
  // than the divisor after an iteration, so WIDTH bits are enough to hold
  // it; the extra bit is only needed transiently for the trial subtract.
  function automatic logic [WIDTH:0] div_step(
    input logic [WIDTH-1:0] r,
    input logic             q_msb,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH:0] s;
    logic [WIDTH:0] t;
    s = {r, q_msb};
    t = s - {1'b0, d};
    if (!t[WIDTH]) begin
      div_step = {1'b1, t[WIDTH-1:0]};
    end else begin
      div_step = {1'b0, s[WIDTH-1:0]};
    end
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;

  logic             accept;
  logic             divisor_zero;
  logic             in_run;
  logic             last_iter;
  logic [WIDTH:0]   step;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // Decode handshake conditions and the combinational iteration result.
  always_comb begin
    accept       = (state == ST_IDLE) && start;
    divisor_zero = (divisor == '0);
    in_run       = (state == ST_RUN);
    last_iter    = in_run && (count == CNT_W'(1));
    step         = div_step(r_reg, q_reg[WIDTH-1], d_reg);
    q_next       = {q_reg[WIDTH-2:0], step[WIDTH]};
    r_next       = step[WIDTH-1:0];
  end

  // Control FSM: IDLE -> RUN (WIDTH cycles) -> DONE (1 cycle) -> IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            count <= CNT_W'(WIDTH);
            state <= divisor_zero ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Working registers: operands are captured on accept, then shifted each RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_reg <= '0;
      q_reg <= '0;
      r_reg <= '0;
    end else if (accept) begin
      d_reg <= divisor;
      q_reg <= dividend;
      r_reg <= '0;
    end else if (in_run) begin
      q_reg <= q_next;
      r_reg <= r_next;
    end
  end

  // Result registers: update only on the zero-divisor accept or the final iteration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      div_by_zero <= divisor_zero;
      if (divisor_zero) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (last_iter) begin
      quotient  <= q_next;
      remainder <= r_next;
    end
  end

endmodule

// File: tb/tb_div_restoring.sv
// Testbench for div_restoring (WIDTH = 8). Stimulus pushes the hand-computed
// expected result into a queue; a monitor pops and compares on every done.
module tb_div_restoring;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected entries: {div_by_zero, quotient, remainder}
  logic [2*W:0] sb[$];

  // Start-held-high vector table (hand computed)
  logic [W-1:0] ha [0:11] = '{8'd17, 8'd250, 8'd1, 8'd128, 8'd99, 8'd255,
                              8'd60, 8'd200, 8'd64, 8'd3, 8'd144, 8'd100};
  logic [W-1:0] hb [0:11] = '{8'd4, 8'd16, 8'd1, 8'd3, 8'd10, 8'd2,
                              8'd7, 8'd13, 8'd64, 8'd200, 8'd12, 8'd7};
  logic [W-1:0] hq [0:11] = '{8'd4, 8'd15, 8'd1, 8'd42, 8'd9, 8'd127,
                              8'd8, 8'd15, 8'd1, 8'd0, 8'd12, 8'd14};
  logic [W-1:0] hr [0:11] = '{8'd1, 8'd10, 8'd0, 8'd2, 8'd9, 8'd1,
                              8'd4, 8'd5, 8'd0, 8'd3, 8'd0, 8'd2};

  always #5 clk = ~clk;

  div_restoring #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    logic [2*W:0] e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", int'(done), 0);
      end else begin
        e = sb.pop_front();
        check("quotient",    int'(quotient),    int'(e[2*W-1:W]));
        check("remainder",   int'(remainder),   int'(e[W-1:0]));
        check("div_by_zero", int'(div_by_zero), int'(e[2*W]));
      end
    end
  end

  // Issue one operation from IDLE (called at a negedge) and wait for its done.
  // With poke set, a second start (50/5) is driven mid-RUN and the held
  // results of the previous 100/7 are checked while running.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez, input bit poke, output int nbusy);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back({ez, eq, er});
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (busy) nbusy++;
      if (poke && i == 3) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        check("hold_quotient_in_run",  int'(quotient),  14);
        check("hold_remainder_in_run", int'(remainder), 2);
      end
      if (poke && i == 4) start = 1'b0;
      if (done) break;
    end
    check("op_done_seen", int'(done), 1);
    @(negedge clk);
    check("idle_after_done", int'(busy), 0);
  endtask

  initial begin : stim
    int nb;
    int idx;
    int cyc;
    int last;
    int ndone;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",        int'(busy),        0);
    check("reset_done",        int'(done),        0);
    check("reset_quotient",    int'(quotient),    0);
    check("reset_remainder",   int'(remainder),   0);
    check("reset_div_by_zero", int'(div_by_zero), 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic divide and its latency
    run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, nb);
    check("busy_cycles_100_7", nb, 9);
    // Start during RUN is ignored
    run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1, nb);
    check("busy_cycles_poke", nb, 9);
    // Boundary operands
    run_op(8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 1'b0, nb);
    run_op(8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 1'b0, nb);
    run_op(8'd5,   8'd9,   8'd0,   8'd5, 1'b0, 1'b0, nb);
    run_op(8'd0,   8'd3,   8'd0,   8'd0, 1'b0, 1'b0, nb);
    // Divide by zero short path, then cleared by a normal divide
    run_op(8'd200, 8'd0, 8'd255, 8'd200, 1'b1, 1'b0, nb);
    check("busy_cycles_dbz", nb, 1);
    run_op(8'd10, 8'd3, 8'd3, 8'd1, 1'b0, 1'b0, nb);

    // Reset after the 4th RUN edge: no done, outputs cleared
    start    = 1'b1;
    dividend = 8'd77;
    divisor  = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy",        int'(busy),        0);
    check("abort_done",        int'(done),        0);
    check("abort_quotient",    int'(quotient),    0);
    check("abort_remainder",   int'(remainder),   0);
    check("abort_div_by_zero", int'(div_by_zero), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_stays_idle", int'(busy), 0);
    run_op(8'd81, 8'd9, 8'd9, 8'd0, 1'b0, 1'b0, nb);

    // Start held high: back-to-back operations, fixed done spacing
    start    = 1'b1;
    dividend = ha[0];
    divisor  = hb[0];
    sb.push_back({1'b0, hq[0], hr[0]});
    idx   = 1;
    cyc   = 0;
    last  = -1;
    ndone = 0;
    while (ndone < 12 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (last >= 0) check("done_period", cyc - last, W + 2);
        last = cyc;
        ndone++;
        if (idx < 12) begin
          dividend = ha[idx];
          divisor  = hb[idx];
          sb.push_back({1'b0, hq[idx], hr[idx]});
          idx++;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("held_done_count", ndone, 12);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
